fifo_handshake_rx: RTL and testbench

Receiving end of the router-to-router RTS/DCTS link. The upstream output arbiter raises RTS and holds it until it samples DCTS. This block answers with a one-cycle DCTS pulse, captures the flit on that handshake cycle, and buffers it in a DEPTH-entry FIFO. The FIFO is drained by the local input-port logic through read_en; its head flit and flags feed the routing/request logic of this router's arbiters.

---
 rtl/fifo_handshake_rx_if.sv | 48 ++++
 rtl/fifo_handshake_rx.sv | 80 ++++++++
 tb/tb_fifo_handshake_rx.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_handshake_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_handshake_rx_if
// Purpose  : Bundles the RTS/DCTS receive link and the local FIFO drain port
//            of fifo_handshake_rx.
// Signals  : RTS      - request-to-send from the upstream arbiter
//            RX       - flit from upstream, valid while RTS=1
//            DCTS     - one-cycle clear-to-send pulse back to upstream
//            read_en  - pop request from local input-port logic
//            Data_out - head-of-FIFO flit (show-ahead)
//            empty    - FIFO holds no flits
//            full     - FIFO holds DEPTH flits
// Modports : slave  - the receiving FIFO
//            master - the surrounding logic (upstream sender + local reader)
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_handshake_rx_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  RTS;
    logic [DATA_WIDTH-1:0] RX;
    logic                  DCTS;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] Data_out;
    logic                  empty;
    logic                  full;

    modport slave (
        input  RTS,
        input  RX,
        input  read_en,
        output DCTS,
        output Data_out,
        output empty,
        output full
    );

    modport master (
        output RTS,
        output RX,
        output read_en,
        input  DCTS,
        input  Data_out,
        input  empty,
        input  full
    );
endinterface
`default_nettype wire

// File: rtl/fifo_handshake_rx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_handshake_rx
// Purpose  : Receiving end of the router-to-router RTS/DCTS link. Answers a
//            held RTS with a one-cycle registered DCTS pulse, captures RX on
//            the handshake cycle and buffers it in a DEPTH-entry FIFO that the
//            local input-port logic drains through read_en.
// Ports    : clk - system clock, rising edge
//            rst - synchronous reset, active low
//            bus - fifo_handshake_rx_if.slave (RTS, RX, DCTS, read_en,
//                  Data_out, empty, full)
// Revision : 1.0 - initial release
// ============================================================================
module fifo_handshake_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  wire                  clk,
    input  wire                  rst,
    fifo_handshake_rx_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_depth = (PTR_W+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_count;
    logic                  r_dcts;

    logic                  w_write;
    logic                  w_read;
    logic                  w_empty;
    logic [PTR_W:0]        w_count_next;
    logic                  w_dcts_next;

    assign w_empty = (r_count == '0);

    // A transfer completes on the edge where upstream still holds RTS while
    // our DCTS pulse is visible. RTS dropped during DCTS writes nothing.
    assign w_write = bus.RTS & r_dcts;
    assign w_read  = bus.read_en & ~w_empty;

    assign w_count_next = r_count + (PTR_W+1)'(w_write) - (PTR_W+1)'(w_read);

    // Looking at next-cycle occupancy guarantees a free slot for the write
    // that the pulse grants, and lets a read in this cycle re-open the link
    // without an extra bubble. ~r_dcts keeps the pulse one cycle wide.
    assign w_dcts_next = bus.RTS & ~r_dcts & (w_count_next < c_depth);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dcts   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_dcts  <= w_dcts_next;
            r_count <= w_count_next;
            if (w_write) begin
                r_mem[r_wr_ptr] <= bus.RX;
                r_wr_ptr        <= r_wr_ptr + 1'b1;   // DEPTH is a power of two
            end
            if (w_read) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign bus.DCTS     = r_dcts;
    // Show-ahead head flit; stale when empty, consumers qualify with empty.
    assign bus.Data_out = r_mem[r_rd_ptr];
    assign bus.empty    = w_empty;
    assign bus.full     = (r_count == c_depth);

endmodule
`default_nettype wire

// File: tb/tb_fifo_handshake_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_handshake_rx
// Purpose  : Directed self-checking bench for fifo_handshake_rx (DEPTH=4,
//            DATA_WIDTH=32) covering reset, single transfer, fill to full,
//            read-unblocks-write with pointer wrap, simultaneous read/write,
//            empty read and reset during a handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_handshake_rx;
    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 4;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    fifo_handshake_rx_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

    fifo_handshake_rx #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Present a flit with RTS high, wait for DCTS, then let the write edge
    // pass. RTS is left high so the caller can chain flits back-to-back.
    task automatic send_flit(input logic [DATA_WIDTH-1:0] data, output int waits);
        bus.RTS = 1'b1;
        bus.RX  = data;
        waits   = 0;
        while (bus.DCTS !== 1'b1 && waits < 10) begin
            tick();
            waits++;
        end
        tests_run++;
        if (bus.DCTS !== 1'b1) begin
            tests_failed++;
            $display("FAIL send_dcts_timeout: flit %h DCTS=%b after %0d cycles, required 1", data, bus.DCTS, waits);
        end else begin
            tick();
            tests_run++;
            if (bus.DCTS !== 1'b0) begin
                tests_failed++;
                $display("FAIL dcts_pulse_width: flit %h DCTS=%b after write edge, required 0", data, bus.DCTS);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.RTS = 1'b1;
        bus.RX  = 32'hDEAD_BEEF;
        tick();
        tick();
        tests_run++;
        if ({bus.DCTS, bus.empty, bus.full} !== 3'b010) begin
            tests_failed++;
            $display("FAIL reset_flags: DCTS/empty/full=%b, required 010", {bus.DCTS, bus.empty, bus.full});
        end
        tests_run++;
        if (bus.Data_out !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data: Data_out=%h, required 00000000", bus.Data_out);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if (bus.DCTS !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_dcts: DCTS=%b, required 1", bus.DCTS);
        end
        // Upstream drops RTS during DCTS: no write, DCTS falls.
        bus.RTS = 1'b0;
        tick();
        tests_run++;
        if ({bus.DCTS, bus.empty} !== 2'b01) begin
            tests_failed++;
            $display("FAIL rts_drop_no_write: DCTS/empty=%b, required 01", {bus.DCTS, bus.empty});
        end
    endtask

    task automatic test_single();
        int waits;
        send_flit(32'hA5A5_0001, waits);
        bus.RTS = 1'b0;
        tests_run++;
        if ({bus.empty, bus.full} !== 2'b00 || dut.r_count !== 3'd1) begin
            tests_failed++;
            $display("FAIL single_count: empty/full=%b count=%0d, required 00 and 1", {bus.empty, bus.full}, dut.r_count);
        end
        tests_run++;
        if (bus.Data_out !== 32'hA5A5_0001) begin
            tests_failed++;
            $display("FAIL single_data: Data_out=%h, required a5a50001", bus.Data_out);
        end
        bus.read_en = 1'b1;
        tick();
        bus.read_en = 1'b0;
        tests_run++;
        if (bus.empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_pop: empty=%b, required 1", bus.empty);
        end
    endtask

    task automatic test_fill();
        int waits;
        logic [DATA_WIDTH-1:0] d;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            d = 32'h11 * (i + 1);
            send_flit(d, waits);
            tests_run++;
            if (waits != 1) begin
                tests_failed++;
                $display("FAIL fill_alternate: flit %h waited %0d cycles for DCTS, required 1", d, waits);
            end
        end
        tests_run++;
        if ({bus.full, bus.empty} !== 2'b10) begin
            tests_failed++;
            $display("FAIL fill_full: full/empty=%b, required 10", {bus.full, bus.empty});
        end
        bus.RTS = 1'b1;
        bus.RX  = 32'h55;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (bus.DCTS !== 1'b0) begin
                tests_failed++;
                $display("FAIL full_blocks_dcts: cycle %0d DCTS=%b, required 0", i, bus.DCTS);
            end
        end
        tests_run++;
        if (bus.Data_out !== 32'h11) begin
            tests_failed++;
            $display("FAIL fill_head: Data_out=%h, required 00000011", bus.Data_out);
        end
    endtask

    task automatic test_read_unblocks();
        bus.read_en = 1'b1;
        tick();
        bus.read_en = 1'b0;
        tests_run++;
        if (bus.Data_out !== 32'h22) begin
            tests_failed++;
            $display("FAIL unblock_head: Data_out=%h, required 00000022", bus.Data_out);
        end
        tests_run++;
        if ({bus.DCTS, bus.full} !== 2'b10) begin
            tests_failed++;
            $display("FAIL unblock_dcts: DCTS/full=%b, required 10", {bus.DCTS, bus.full});
        end
        tick();
        bus.RTS = 1'b0;
        tests_run++;
        if ({bus.DCTS, bus.full} !== 2'b01) begin
            tests_failed++;
            $display("FAIL unblock_refill: DCTS/full=%b, required 01", {bus.DCTS, bus.full});
        end
        tests_run++;
        if (dut.r_mem[0] !== 32'h55) begin
            tests_failed++;
            $display("FAIL wrap_write: mem[0]=%h, required 00000055", dut.r_mem[0]);
        end
    endtask

    task automatic test_simultaneous();
        logic [DATA_WIDTH-1:0] exp_q [2];
        // Drain 0x22 and 0x33 to bring occupancy to two: {0x44, 0x55}.
        bus.read_en = 1'b1;
        tick();
        tick();
        bus.read_en = 1'b0;
        tests_run++;
        if (bus.Data_out !== 32'h44 || dut.r_count !== 3'd2) begin
            tests_failed++;
            $display("FAIL simul_setup: Data_out=%h count=%0d, required 00000044 and 2", bus.Data_out, dut.r_count);
        end
        bus.RTS = 1'b1;
        bus.RX  = 32'h66;
        tick();
        tests_run++;
        if (bus.DCTS !== 1'b1) begin
            tests_failed++;
            $display("FAIL simul_dcts: DCTS=%b, required 1", bus.DCTS);
        end
        bus.read_en = 1'b1;
        tick();
        bus.read_en = 1'b0;
        bus.RTS     = 1'b0;
        tests_run++;
        if (dut.r_count !== 3'd2 || {bus.empty, bus.full} !== 2'b00) begin
            tests_failed++;
            $display("FAIL simul_count: count=%0d empty/full=%b, required 2 and 00", dut.r_count, {bus.empty, bus.full});
        end
        exp_q[0] = 32'h55;
        exp_q[1] = 32'h66;
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (bus.Data_out !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL simul_order: pop %0d Data_out=%h, required %h", i, bus.Data_out, exp_q[i]);
            end
            bus.read_en = 1'b1;
            tick();
            bus.read_en = 1'b0;
        end
        tests_run++;
        if (bus.empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL simul_drained: empty=%b, required 1", bus.empty);
        end
    endtask

    task automatic test_empty_and_reset();
        // rd_ptr now sits on entry 2, which still holds the stale 0x33.
        bus.read_en = 1'b1;
        tick();
        bus.read_en = 1'b0;
        tests_run++;
        if (bus.empty !== 1'b1 || dut.r_count !== 3'd0 || bus.Data_out !== 32'h33) begin
            tests_failed++;
            $display("FAIL empty_read: empty=%b count=%0d Data_out=%h, required 1, 0, 00000033", bus.empty, dut.r_count, bus.Data_out);
        end
        bus.RTS = 1'b1;
        bus.RX  = 32'h77;
        tick();
        tests_run++;
        if (bus.DCTS !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_dcts: DCTS=%b, required 1", bus.DCTS);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if ({bus.DCTS, bus.empty} !== 2'b01 || bus.Data_out !== 32'h0) begin
            tests_failed++;
            $display("FAIL midreset_drop: DCTS/empty=%b Data_out=%h, required 01 and 00000000", {bus.DCTS, bus.empty}, bus.Data_out);
        end
        rst     = 1'b1;
        bus.RTS = 1'b0;
        tick();
        tests_run++;
        if (bus.empty !== 1'b1 || dut.r_count !== 3'd0 || bus.DCTS !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_after: empty=%b count=%0d DCTS=%b, required 1, 0, 0", bus.empty, dut.r_count, bus.DCTS);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        bus.RTS      = 1'b0;
        bus.RX       = '0;
        bus.read_en  = 1'b0;
        #2;
        test_reset();
        test_single();
        test_fill();
        test_read_unblocks();
        test_simultaneous();
        test_empty_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
`default_nettype wire
